core_clk_rst_sequencer: RTL

// Sequences clock enable and reset for one GPU compute core. Sits between the cache-side

---
 rtl/core_clk_rst_sequencer_if.sv | 22 ++
 rtl/core_clk_rst_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/core_clk_rst_sequencer_if.sv
// Handshake bundle between the config-register side and the core clock/reset
// sequencer. The master drives the request and idle inputs; the sequencer
// (slave) drives the clock-enable and reset outputs toward the gating cell.
interface core_clk_rst_sequencer_if;
  logic en_req_i;
  logic force_off_i;
  logic core_idle_i;
  logic clk_core_en_o;
  logic rst_n_core_o;
  logic active_o;
  logic busy_o;

  modport master (
    output en_req_i, force_off_i, core_idle_i,
    input  clk_core_en_o, rst_n_core_o, active_o, busy_o
  );

  modport slave (
    input  en_req_i, force_off_i, core_idle_i,
    output clk_core_en_o, rst_n_core_o, active_o, busy_o
  );
endinterface

// File: rtl/core_clk_rst_sequencer.sv
// Clock-enable / reset sequencer for one compute core. A single FSM orders
// power-up (clock on, then reset released) and power-down (drain until idle,
// reset asserted, then clock off) so the gated clock never toggles into a
// running core and reset is always applied with the clock running.
module core_clk_rst_sequencer #(
  parameter int RST_CYCLES  = 4,
  parameter int IDLE_CYCLES = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  core_clk_rst_sequencer_if.slave         bus
);

  localparam int CNT_MAX = (RST_CYCLES > IDLE_CYCLES) ? RST_CYCLES : IDLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_PWRUP,
    ST_RUN,
    ST_DRAIN,
    ST_PWRDN
  } state_t;

  typedef struct packed {
    logic clk_en;
    logic rst_n;
    logic active;
    logic busy;
  } outs_t;

  localparam outs_t OUTS_OFF = '{clk_en: 1'b0, rst_n: 1'b0, active: 1'b0, busy: 1'b0};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  outs_t            outs_q, outs_d;

  // Next-state, counter and output decode for the sequencer FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    outs_d  = OUTS_OFF;

    unique case (state_q)
      ST_OFF: begin
        // A stray force_off while off keeps the core off.
        if (!bus.force_off_i && bus.en_req_i) state_d = ST_PWRUP;
      end

      ST_PWRUP: begin
        // Reset is already held low here, so aborting goes straight to PWRDN
        // which finishes the reset window before the clock is removed.
        if (bus.force_off_i)      state_d = ST_PWRDN;
        else if (cnt_q == RST_LAST) state_d = ST_RUN;
        else if (!bus.en_req_i)   state_d = ST_PWRDN;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end

      ST_RUN: begin
        if (bus.force_off_i)    state_d = ST_PWRDN;
        else if (!bus.en_req_i) state_d = ST_DRAIN;
      end

      ST_DRAIN: begin
        // The idle run must be consecutive: any busy cycle restarts it.
        if (bus.force_off_i)                          state_d = ST_PWRDN;
        else if (bus.core_idle_i && cnt_q == IDLE_LAST) state_d = ST_PWRDN;
        else if (bus.en_req_i)                        state_d = ST_RUN;
        else if (bus.core_idle_i)                     cnt_d   = cnt_q + CNT_W'(1);
        else                                          cnt_d   = '0;
      end

      ST_PWRDN: begin
        // Requests are ignored: the reset window always completes.
        if (cnt_q == RST_LAST) state_d = ST_OFF;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end

      default: state_d = ST_OFF;
    endcase

    // Every state entry starts the counter from zero.
    if (state_d != state_q) cnt_d = '0;

    // Outputs are decoded from the state being entered so that, once
    // registered, they line up exactly with the state register.
    unique case (state_d)
      ST_PWRUP: outs_d = '{clk_en: 1'b1, rst_n: 1'b0, active: 1'b0, busy: 1'b1};
      ST_RUN:   outs_d = '{clk_en: 1'b1, rst_n: 1'b1, active: 1'b1, busy: 1'b0};
      ST_DRAIN: outs_d = '{clk_en: 1'b1, rst_n: 1'b1, active: 1'b0, busy: 1'b1};
      ST_PWRDN: outs_d = '{clk_en: 1'b1, rst_n: 1'b0, active: 1'b0, busy: 1'b1};
      default:  outs_d = OUTS_OFF;
    endcase
  end

  // State, counter and registered outputs; async reset forces OFF values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      outs_q  <= OUTS_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      outs_q  <= outs_d;
    end
  end

  assign bus.clk_core_en_o = outs_q.clk_en;
  assign bus.rst_n_core_o  = outs_q.rst_n;
  assign bus.active_o      = outs_q.active;
  assign bus.busy_o        = outs_q.busy;

endmodule
